// File: rtl/pdm_mic_array.sv
// Multi-microphone PDM front end: PDM clock generation, per-channel CIC decimation
// and a channel-serial valid/ready output with warm-up suppression and overrun flag.
module pdm_mic_array #(
  parameter int N_MICS  = 2,
  parameter int CLK_DIV = 6,
  parameter int DECIM   = 64,
  parameter int ORDER   = 4,
  parameter int OUT_W   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic                          pdm_clk,
  input  logic [N_MICS-1:0]             pdm_data,
  output logic [OUT_W-1:0]              out_data,
  output logic [$clog2(2*N_MICS)-1:0]   out_chan,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overrun
);

  localparam int N_CH = 2 * N_MICS;
  localparam int CH_W = $clog2(N_CH);
  localparam int W    = ORDER * $clog2(DECIM) + 2;
  localparam int PH_W = $clog2(2 * CLK_DIV);
  localparam int DC_W = $clog2(DECIM);
  localparam int WU_W = $clog2(ORDER + 1);

  typedef enum logic {S_IDLE, S_SEND} state_e;

  logic [PH_W-1:0]   ph_q, ph_d;
  logic              pdm_clk_q, pdm_clk_d;
  logic [N_MICS-1:0] meta_q, sync_q;
  logic [DC_W-1:0]   dc_q, dc_d;
  logic [WU_W-1:0]   warm_q, warm_d;
  state_e            state_q, state_d;
  logic [CH_W-1:0]   chan_q, chan_d;
  logic              overrun_q, overrun_d;
  logic [W-1:0]      integ_q [N_CH][ORDER];
  logic [W-1:0]      integ_d [N_CH][ORDER];
  logic [W-1:0]      dly_q   [N_CH][ORDER];
  logic [W-1:0]      dly_d   [N_CH][ORDER];
  logic [OUT_W-1:0]  buf_q   [N_CH];
  logic [OUT_W-1:0]  buf_d   [N_CH];

  logic en_left, en_right, frame_stb, emit;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    ph_d      = (ph_q == PH_W'(2 * CLK_DIV - 1)) ? '0 : ph_q + 1'b1;
    pdm_clk_d = (ph_d < PH_W'(CLK_DIV));
    en_left   = (ph_q == PH_W'(CLK_DIV - 1));
    en_right  = (ph_q == PH_W'(2 * CLK_DIV - 1));
    dc_d      = en_right ? dc_q + DC_W'(1) : dc_q;
    frame_stb = en_right && (dc_q == DC_W'(DECIM - 1));
    emit      = frame_stb && (warm_q == WU_W'(ORDER));
  end

  // Each integrator stage adds the previous stage's registered value; the extra
  // pipeline delay does not change the decimated result.
  always_comb begin
    integ_d = integ_q;
    for (int c = 0; c < N_CH; c++) begin
      if ((c % 2 == 0) ? en_left : en_right) begin
        integ_d[c][0] = integ_q[c][0] + (sync_q[c/2] ? W'(1) : {W{1'b1}});
        for (int k = 1; k < ORDER; k++) begin
          integ_d[c][k] = integ_q[c][k] + integ_q[c][k-1];
        end
      end
    end
  end

  always_comb begin
    logic [W-1:0] x;
    x     = '0;
    dly_d = dly_q;
    buf_d = buf_q;
    if (frame_stb) begin
      for (int c = 0; c < N_CH; c++) begin
        x = integ_q[c][ORDER-1];
        for (int k = 0; k < ORDER; k++) begin
          dly_d[c][k] = x;
          x = x - dly_q[c][k];
        end
        buf_d[c] = x[W-1 -: OUT_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    overrun_d = overrun_q;
    warm_d    = warm_q;
    if (frame_stb && (warm_q != WU_W'(ORDER))) begin
      warm_d = warm_q + WU_W'(1);
    end
    if (emit) begin
      // A new frame always wins; anything still unsent from the old one is lost.
      state_d = S_SEND;
      chan_d  = '0;
      if (state_q == S_SEND) overrun_d = 1'b1;
    end else if (state_q == S_SEND && out_ready) begin
      if (chan_q == CH_W'(N_CH - 1)) begin
        state_d = S_IDLE;
        chan_d  = '0;
      end else begin
        chan_d = chan_q + CH_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph_q      <= '0;
      pdm_clk_q <= 1'b0;
      meta_q    <= '0;
      sync_q    <= '0;
      dc_q      <= '0;
      warm_q    <= '0;
      state_q   <= S_IDLE;
      chan_q    <= '0;
      overrun_q <= 1'b0;
      // NOTE: these arrays are small register files that must start from zero, so they are reset like any flop.
      for (int c = 0; c < N_CH; c++) begin
        buf_q[c] <= '0;
        for (int k = 0; k < ORDER; k++) begin
          integ_q[c][k] <= '0;
          dly_q[c][k]   <= '0;
        end
      end
    end else begin
      ph_q      <= ph_d;
      pdm_clk_q <= pdm_clk_d;
      meta_q    <= pdm_data;
      sync_q    <= meta_q;
      dc_q      <= dc_d;
      warm_q    <= warm_d;
      state_q   <= state_d;
      chan_q    <= chan_d;
      overrun_q <= overrun_d;
      integ_q   <= integ_d;
      dly_q     <= dly_d;
      buf_q     <= buf_d;
    end
  end

  assign pdm_clk   = pdm_clk_q;
  assign out_valid = (state_q == S_SEND);
  assign out_chan  = chan_q;
  assign out_last  = out_valid && (chan_q == CH_W'(N_CH - 1));
  assign out_data  = buf_q[chan_q];
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pdm_mic_array.sv
// Directed bench for pdm_mic_array at default parameters: reset, clocking,
// steady-state sample values, left/right separation, backpressure and overrun.
module tb_pdm_mic_array;

  localparam int FRAME_CLK   = 768;
  localparam int FIRST_VALID = 3840;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pdm_clk;
  logic [1:0]  pdm_data = '0;
  logic [15:0] out_data;
  logic [1:0]  out_chan;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        overrun;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus pattern: 0 = constant, 1 = mic0 high only in the left slot, 2 = mic0 alternating per PDM period
  int         pat_mode  = 0;
  logic [1:0] pat_const = '0;
  logic       alt_bit   = 1'b0;
  logic       pclk_prev = 1'b0;

  logic [15:0] got_data  [4];
  logic [1:0]  got_chan  [4];
  logic        got_last  [4];
  logic        got_valid [4];
  logic        got_timeout;

  pdm_mic_array dut (
    .clk       (clk),
    .reset     (reset),
    .pdm_clk   (pdm_clk),
    .pdm_data  (pdm_data),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    case (pat_mode)
      1: pdm_data = {pat_const[1], pdm_clk};
      2: begin
        if (pdm_clk && !pclk_prev) alt_bit = ~alt_bit;
        pdm_data = {pat_const[1], alt_bit};
      end
      default: pdm_data = pat_const;
    endcase
    pclk_prev = pdm_clk;
  end

  task automatic start_run(input int mode, input logic [1:0] cval);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    pat_mode  = mode;
    pat_const = cval;
    alt_bit   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic recv_frame(input int budget);
    int n = 0;
    got_timeout = 1'b0;
    while (out_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (out_valid !== 1'b1) got_timeout = 1'b1;
    for (int i = 0; i < 4; i++) begin
      got_data[i]  = out_data;
      got_chan[i]  = out_chan;
      got_last[i]  = out_last;
      got_valid[i] = out_valid;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int first_valid = -1;
    int rise1 = -1, rise2 = -1, fall1 = -1;
    logic prev;
    reset     = 1'b0;
    out_ready = 1'b1;
    pat_mode  = 0;
    pat_const = 2'b11;
    repeat (3) @(negedge clk);
    n_checks++; if (pdm_clk !== 1'b0)    begin n_errors++; $display("FAIL reset_pdm_clk: got %b want 0", pdm_clk); end
    n_checks++; if (out_valid !== 1'b0)  begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== 16'h0)  begin n_errors++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    n_checks++; if (out_chan !== 2'd0)   begin n_errors++; $display("FAIL reset_out_chan: got %0d want 0", out_chan); end
    n_checks++; if (out_last !== 1'b0)   begin n_errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    n_checks++; if (overrun !== 1'b0)    begin n_errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    reset = 1'b1;
    prev  = pdm_clk;
    for (int k = 1; k <= FIRST_VALID + 20; k++) begin
      @(negedge clk);
      if (k >= 100) begin
        if (pdm_clk && !prev) begin
          if (rise1 < 0) rise1 = k;
          else if (rise2 < 0) rise2 = k;
        end
        if (!pdm_clk && prev && rise1 >= 0 && fall1 < 0) fall1 = k;
      end
      prev = pdm_clk;
      if (out_valid === 1'b1) begin
        first_valid = k;
        break;
      end
    end
    n_checks++; if (rise2 - rise1 !== 12) begin n_errors++; $display("FAIL pdm_clk_period: got %0d want 12", rise2 - rise1); end
    n_checks++; if (fall1 - rise1 !== 6)  begin n_errors++; $display("FAIL pdm_clk_high: got %0d want 6", fall1 - rise1); end
    n_checks++; if (first_valid !== FIRST_VALID) begin
      n_errors++; $display("FAIL first_valid_latency: got %0d want %0d", first_valid, FIRST_VALID);
    end
  endtask

  task automatic test_ones;
    logic [15:0] exp_d [4] = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
    start_run(0, 2'b11);
    for (int f = 0; f < 2; f++) begin
      recv_frame((f == 0) ? FIRST_VALID + 100 : FRAME_CLK + 10);
      n_checks++; if (got_timeout !== 1'b0) begin n_errors++; $display("FAIL ones_timeout frame %0d: got timeout want frame", f); end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (got_valid[i] !== 1'b1 || got_chan[i] !== 2'(i) || got_last[i] !== (i == 3) || got_data[i] !== exp_d[i]) begin
          n_errors++;
          $display("FAIL ones f%0d w%0d: got v=%b ch=%0d last=%b d=%h want v=1 ch=%0d last=%b d=%h",
                   f, i, got_valid[i], got_chan[i], got_last[i], got_data[i], i, (i == 3), exp_d[i]);
        end
      end
    end
  endtask

  task automatic run_pattern(input string name, input int mode, input logic [1:0] cval,
                             input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] exp_d [4];
    exp_d = '{e0, e1, e2, e3};
    start_run(mode, cval);
    recv_frame(FIRST_VALID + 100);
    n_checks++; if (got_timeout !== 1'b0) begin n_errors++; $display("FAIL %s_timeout: got timeout want frame", name); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_valid[i] !== 1'b1 || got_chan[i] !== 2'(i) || got_data[i] !== exp_d[i]) begin
        n_errors++;
        $display("FAIL %s w%0d: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                 name, i, got_valid[i], got_chan[i], got_data[i], i, exp_d[i]);
      end
    end
  endtask

  task automatic test_mixed;
    run_pattern("mixed", 0, 2'b10, 16'hC000, 16'hC000, 16'h4000, 16'h4000);
  endtask

  task automatic test_alternate;
    run_pattern("alternate", 2, 2'b10, 16'h0000, 16'h0000, 16'h4000, 16'h4000);
  endtask

  task automatic test_left_right;
    run_pattern("left_right", 1, 2'b10, 16'h4000, 16'hC000, 16'h4000, 16'h4000);
  endtask

  task automatic test_backpressure;
    int n = 0;
    logic [15:0] snap_d;
    logic [1:0]  snap_c;
    logic        snap_l;
    start_run(0, 2'b11);
    while (out_valid !== 1'b1 && n < FIRST_VALID + 100) begin @(negedge clk); n++; end
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_timeout: got out_valid=%b want 1", out_valid); end
    @(negedge clk);
    out_ready = 1'b0;
    snap_d = out_data;
    snap_c = out_chan;
    snap_l = out_last;
    n_checks++; if (snap_c !== 2'd1) begin n_errors++; $display("FAIL bp_stall_chan: got %0d want 1", snap_c); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== snap_d || out_chan !== snap_c || out_last !== snap_l || overrun !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_hold cyc%0d: got v=%b d=%h ch=%0d last=%b ovr=%b want v=1 d=%h ch=%0d last=%b ovr=0",
                 k, out_valid, out_data, out_chan, out_last, overrun, snap_d, snap_c, snap_l);
      end
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_chan !== 2'(i) || out_last !== (i == 3) || out_data !== 16'h4000) begin
        n_errors++;
        $display("FAIL bp_resume w%0d: got v=%b ch=%0d last=%b d=%h want v=1 ch=%0d last=%b d=4000",
                 i, out_valid, out_chan, out_last, out_data, i, (i == 3));
      end
      @(negedge clk);
    end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_idle: got out_valid=%b want 0", out_valid); end
    n_checks++; if (overrun !== 1'b0)   begin n_errors++; $display("FAIL bp_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_overrun;
    int n = 0;
    start_run(0, 2'b11);
    while (out_valid !== 1'b1 && n < FIRST_VALID + 100) begin @(negedge clk); n++; end
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL ovr_timeout: got out_valid=%b want 1", out_valid); end
    repeat (2) @(negedge clk);
    n_checks++; if (out_chan !== 2'd2 || overrun !== 1'b0) begin
      n_errors++; $display("FAIL ovr_pre: got ch=%0d ovr=%b want ch=2 ovr=0", out_chan, overrun);
    end
    out_ready = 1'b0;
    repeat (800) @(negedge clk);
    n_checks++; if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
    n_checks++; if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 16'h4000) begin
      n_errors++; $display("FAIL ovr_restart: got v=%b ch=%0d d=%h want v=1 ch=0 d=4000", out_valid, out_chan, out_data);
    end
    out_ready = 1'b1;
    recv_frame(5);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_valid[i] !== 1'b1 || got_chan[i] !== 2'(i) || got_last[i] !== (i == 3) || got_data[i] !== 16'h4000) begin
        n_errors++;
        $display("FAIL ovr_recover w%0d: got v=%b ch=%0d last=%b d=%h want v=1 ch=%0d last=%b d=4000",
                 i, got_valid[i], got_chan[i], got_last[i], got_data[i], i, (i == 3));
      end
    end
    n_checks++; if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    n = 0;
    while (out_valid !== 1'b1 && n < FRAME_CLK + 50) begin @(negedge clk); n++; end
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL ovr_next_timeout: got out_valid=%b want 1", out_valid); end
    reset = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || overrun !== 1'b0) begin
      n_errors++; $display("FAIL midstream_reset: got v=%b ovr=%b want v=0 ovr=0", out_valid, overrun);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset;
    test_ones;
    test_mixed;
    test_alternate;
    test_left_right;
    test_backpressure;
    test_overrun;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
